// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, default widths and small helpers for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MAX_STARVE_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Starvation count after a DM grant: saturating step while IF waits, cleared otherwise.
    function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                               input logic [3:0] limit,
                                               input logic       if_pending);
        logic [3:0] nxt;
        if (!if_pending) begin
            nxt = 4'd0;
        end else if (cnt >= limit) begin
            nxt = limit;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and the shared memory port.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_perf.sv
// Performance counters for the arbiter; only compiled when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic        if_done,
    input  logic        dm_gnt,
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_dm_txn
);

    logic [31:0] if_stall_r;
    logic [31:0] dm_txn_r;

    // Free-running counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_stall_r <= 32'd0;
            dm_txn_r   <= 32'd0;
        end else begin
            if (if_req && !if_done) begin
                if_stall_r <= if_stall_r + 32'd1;
            end
            if (dm_gnt) begin
                dm_txn_r <= dm_txn_r + 32'd1;
            end
        end
    end

    assign perf_if_stall = if_stall_r;
    assign perf_dm_txn   = dm_txn_r;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and data (DM) requesters with starvation guard and watchdog.
// Optional counters are enabled with the MEM_ARB_PERF_EN macro.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STARVE = MAX_STARVE_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_txn
`endif
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        state_r;
    arb_owner_t        owner_r;
    logic [3:0]        starve_r;
    logic [WD_W-1:0]   wd_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_done_r;
    logic              dm_done_r;
    logic              err_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;

    logic              starved_s;
    logic              dm_win_s;
    logic              if_win_s;
    logic              timeout_s;
    logic [DATA_W-1:0] resp_data_s;

    // Arbitration decision and completion data; grants are only issued from IDLE.
    always_comb begin
        starved_s   = bus.if_req && (starve_r >= 4'(MAX_STARVE));
        dm_win_s    = (state_r == ST_IDLE) && bus.dm_req && !starved_s;
        if_win_s    = (state_r == ST_IDLE) && bus.if_req && !dm_win_s;
        timeout_s   = (wd_r == WD_W'(TIMEOUT - 1));
        if (bus.mem_ready && !mem_we_r) begin
            resp_data_s = bus.mem_rdata;
        end else begin
            resp_data_s = {DATA_W{1'b0}};
        end
    end

    // FSM, payload latch, watchdog and registered responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_DM;
            starve_r    <= 4'd0;
            wd_r        <= {WD_W{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
            err_r       <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dm_win_s || if_win_s) begin
                        state_r     <= ST_WAIT;
                        owner_r     <= dm_win_s ? OWN_DM : OWN_IF;
                        wd_r        <= {WD_W{1'b0}};
                        mem_req_r   <= 1'b1;
                        // Fetch never writes, so IF payload forces a read.
                        mem_we_r    <= dm_win_s && bus.dm_we;
                        mem_addr_r  <= dm_win_s ? bus.dm_addr : bus.if_addr;
                        mem_wdata_r <= dm_win_s ? bus.dm_wdata : {DATA_W{1'b0}};
                        starve_r    <= dm_win_s ? starve_next(starve_r, 4'(MAX_STARVE), bus.if_req)
                                                : 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_ready || timeout_s) begin
                        state_r     <= ST_RESP;
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= {ADDR_W{1'b0}};
                        mem_wdata_r <= {DATA_W{1'b0}};
                        err_r       <= !bus.mem_ready;
                        if (owner_r == OWN_DM) begin
                            dm_done_r  <= 1'b1;
                            dm_rdata_r <= resp_data_s;
                        end else begin
                            if_done_r  <= 1'b1;
                            if_rdata_r <= resp_data_s;
                        end
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    if_done_r <= 1'b0;
                    dm_done_r <= 1'b0;
                    err_r     <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    if_done_r <= 1'b0;
                    dm_done_r <= 1'b0;
                    err_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_win_s;
    assign bus.dm_gnt    = dm_win_s;
    assign bus.if_done   = if_done_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.err       = err_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

`ifdef MEM_ARB_PERF_EN
    arb_perf_counters u_perf (
        .clk           (clk),
        .rst           (rst),
        .if_req        (bus.if_req),
        .if_done       (if_done_r),
        .dm_gnt        (dm_win_s),
        .perf_if_stall (perf_if_stall),
        .perf_dm_txn   (perf_dm_txn)
    );
`endif

endmodule
